sram_io_ctrl_target: RTL
========================

Name: sram_io_ctrl_target

Overview:
On-chip responder for the SCPU SRAM serial load/readback link. Its signals are bgn, load, mod0, mod1 and si in, and so and rdy out.
- Receives a {addr, data} frame from the FPGA-side initiator, LSB first.
- Returns its previous response frame on so during the same exchange.
- On a bgn rising edge, performs one SRAM write or read.
- Sits between the chip pad interface and the program SRAM macro, which has a synchronous 1-cycle read.

Parameters:
MEMORY_DATA_WIDTH, 8, SRAM data width.
MEMORY_ADDR_WIDTH, 9, SRAM address width.
REG_BITS_WIDTH, MEMORY_ADDR_WIDTH+MEMORY_DATA_WIDTH, serial frame length (must be <=255).

Ports:
csi_clk  in  1  single clock.
rsi_reset_n  in  1  asynchronous active-low reset.
ctrl_bgn  in  1  operation start; rising edge triggers.
ctrl_load  in  1  one-cycle pulse that starts a frame exchange.
ctrl_mod0  in  1  mode bit 0.
ctrl_mod1  in  1  mode bit 1.
ctrl_si  in  1  serial data from initiator.
ctrl_so  out  1  serial data to initiator; equals sr[0].
ctrl_rdy  out  1  high when state==IDLE.
sram_addr  out  MEMORY_ADDR_WIDTH  = frame[REG_BITS_WIDTH-1:MEMORY_DATA_WIDTH].
sram_wdata  out  MEMORY_DATA_WIDTH  = frame[MEMORY_DATA_WIDTH-1:0].
sram_rdata  in  MEMORY_DATA_WIDTH  SRAM read data, valid 1 cycle after a read access.
sram_cs  out  1  chip select.
sram_we  out  1  write enable.

Behaviour:
- Registers:
  - sr: shift register, REG_BITS_WIDTH bits.
  - frame: last received frame.
  - resp: response frame.
  - cnt: 8-bit shift counter.
  - bgn_d: ctrl_bgn delayed one cycle.
  - state: IDLE, SHIFT, WRITE, READ, RWAIT.
- Reset (asynchronous): state=IDLE; sr, frame, resp, cnt, bgn_d all 0. Resulting outputs: ctrl_so=0, ctrl_rdy=1, sram_cs=0, sram_we=0, sram_addr=0, sram_wdata=0.
- Frame format: frame = {addr, data}. Bit 0 goes first on the wire, so data LSB first and addr MSB last.
- IDLE, load sampled 1:
  - sr<=resp, cnt<=REG_BITS_WIDTH, state<=SHIFT.
  - so therefore presents resp[0] during the first shift cycle.
- SHIFT, each edge with cnt!=0:
  - sr<={ctrl_si, sr[REG_BITS_WIDTH-1:1]}, cnt<=cnt-1.
  - On the edge where cnt goes 1->0: frame<={ctrl_si, sr[REG_BITS_WIDTH-1:1]} and state<=IDLE.
  - Exactly REG_BITS_WIDTH shift edges follow the load edge, matching the initiator's shift count.
- Load sampled 1 while in SHIFT: the exchange restarts (sr<=resp, cnt<=REG_BITS_WIDTH). frame is not updated.
- bgn edge detection: bgn_d<=ctrl_bgn every cycle in every state. A bgn rise is ctrl_bgn=1 and bgn_d=0.
- Bgn rise while in IDLE: mode {mod1,mod0} is sampled that cycle.
  - 01: state<=WRITE.
  - 10: state<=READ.
  - 00 or 11: no-op; state stays IDLE and no SRAM access occurs.
- WRITE (1 cycle): sram_cs=1, sram_we=1. Then resp<=frame and state<=IDLE.
- READ (1 cycle): sram_cs=1, sram_we=0. Then state<=RWAIT.
- RWAIT (1 cycle): resp<={frame addr field, sram_rdata}, then state<=IDLE.
- Simultaneous load and bgn rise in IDLE: load wins and the bgn rise is dropped. The initiator must re-raise bgn.
- bgn rise or load outside IDLE: ignored. bgn_d still tracks, so a bgn held high does not retrigger.
- ctrl_rdy is combinational from state. It is low during SHIFT, WRITE, READ and RWAIT.
- Latency:
  - load edge to rdy high: REG_BITS_WIDTH+1 edges.
  - bgn rise to rdy: 1 edge plus 1 cycle for a write; 1 edge plus 2 cycles for a read.
- sram_cs and sram_we decode only from registered state; no other combinational paths feed them.

Test Plan:
1. Reset mid-SHIFT (after 5 shifts): outputs immediately at reset values (rdy=1, so=0). After release, a full exchange of 0x1A53C from reset returns 0x00000 on so.
2. Load frame 0x1A53C, mode 01, bgn rise -> exactly one cycle with sram_cs=1, sram_we=1, sram_addr=0x1A5, sram_wdata=0x3C. rdy is low for that cycle. The next exchange returns 0x1A53C on so.
3. Load frame 0x0F000, mode 10, bgn rise, SRAM model returns 0x5A -> one read cycle with cs=1, we=0, addr=0x0F0. The next exchange shifts out 0x0F05A, LSB first.
4. Mode 11 or 00 with bgn rise -> no sram_cs assertion and rdy stays 1. bgn held high for 10 cycles produces only one operation (checked with mode 01: a single write).
5. Load pulse after 8 shifts -> cnt restarts at 17; frame is unchanged until the full 17-bit frame completes, and the final frame equals the second transmission.
6. Load and bgn rise in the same IDLE cycle with mode 01 -> SHIFT entered and no SRAM write occurs.

Source files
------------

// File: rtl/sram_io_ctrl_target_if.sv
// rtl/sram_io_ctrl_target_if.sv - pad-side serial link and SRAM macro bus bundle
//
// Purpose: groups the initiator link (bgn/load/mode/si/so/rdy) and the
// program SRAM bus into one interface.
// Modports:
//    slave  - the on-chip responder (sram_io_ctrl_target)
//    master - the environment: link initiator plus SRAM macro
// Signals:
//    ctrl_bgn, ctrl_load, ctrl_mod0, ctrl_mod1, ctrl_si  initiator -> target
//    ctrl_so, ctrl_rdy                                   target -> initiator
//    sram_addr, sram_wdata, sram_cs, sram_we             target -> SRAM
//    sram_rdata                                          SRAM -> target
interface sram_io_ctrl_target_if #(
   parameter int MEMORY_DATA_WIDTH = 8,
   parameter int MEMORY_ADDR_WIDTH = 9
);
   logic                         ctrl_bgn;
   logic                         ctrl_load;
   logic                         ctrl_mod0;
   logic                         ctrl_mod1;
   logic                         ctrl_si;
   logic                         ctrl_so;
   logic                         ctrl_rdy;
   logic [MEMORY_ADDR_WIDTH-1:0] sram_addr;
   logic [MEMORY_DATA_WIDTH-1:0] sram_wdata;
   logic [MEMORY_DATA_WIDTH-1:0] sram_rdata;
   logic                         sram_cs;
   logic                         sram_we;

   modport slave (
      input  ctrl_bgn, ctrl_load, ctrl_mod0, ctrl_mod1, ctrl_si, sram_rdata,
      output ctrl_so, ctrl_rdy, sram_addr, sram_wdata, sram_cs, sram_we
   );

   modport master (
      output ctrl_bgn, ctrl_load, ctrl_mod0, ctrl_mod1, ctrl_si, sram_rdata,
      input  ctrl_so, ctrl_rdy, sram_addr, sram_wdata, sram_cs, sram_we
   );
endinterface

// File: rtl/sram_io_ctrl_target.sv
// rtl/sram_io_ctrl_target.sv - SCPU SRAM serial load/readback responder
//
// Purpose: receives a {addr, data} frame LSB first while shifting out the
// previous response frame, then on a bgn rising edge performs one SRAM
// write (mode 01) or read (mode 10) using the last received frame.
// Ports:
//    csi_clk      single clock
//    rsi_reset_n  asynchronous active-low reset
//    bus          sram_io_ctrl_target_if.slave (serial link + SRAM bus)
module sram_io_ctrl_target #(
   parameter int MEMORY_DATA_WIDTH = 8,
   parameter int MEMORY_ADDR_WIDTH = 9,
   parameter int REG_BITS_WIDTH    = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH
) (
   input  logic                         csi_clk,
   input  logic                         rsi_reset_n,
   sram_io_ctrl_target_if.slave         bus
);

   localparam logic [7:0] CNT_LOAD = 8'(REG_BITS_WIDTH);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SHIFT = 3'd1,
      WRITE = 3'd2,
      READ  = 3'd3,
      RWAIT = 3'd4
   } state_t;

   state_t                    state;
   state_t                    state_nx;
   logic [REG_BITS_WIDTH-1:0] sr;
   logic [REG_BITS_WIDTH-1:0] frame;
   logic [REG_BITS_WIDTH-1:0] resp;
   logic [7:0]                cnt;
   logic                      bgn_d;
   logic                      bgn_rise;
   logic [1:0]                mode;
   logic [REG_BITS_WIDTH-1:0] sr_shift;

   assign bgn_rise = bus.ctrl_bgn & ~bgn_d;
   assign mode     = {bus.ctrl_mod1, bus.ctrl_mod0};
   // New bits enter at the top so the first bit received ends up in bit 0.
   assign sr_shift = {bus.ctrl_si, sr[REG_BITS_WIDTH-1:1]};

   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // load takes priority over a bgn rise in IDLE; the rise is simply lost.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (bus.ctrl_load) begin
               state_nx = SHIFT;
            end else if (bgn_rise) begin
               case (mode)
                  2'b01:   state_nx = WRITE;
                  2'b10:   state_nx = READ;
                  default: state_nx = IDLE;
               endcase
            end
         end
         SHIFT: begin
            if (bus.ctrl_load) begin
               state_nx = SHIFT;
            end else if (cnt <= 8'd1) begin
               state_nx = IDLE;
            end
         end
         WRITE:   state_nx = IDLE;
         READ:    state_nx = RWAIT;
         RWAIT:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         sr    <= '0;
         frame <= '0;
         resp  <= '0;
         cnt   <= '0;
         bgn_d <= 1'b0;
      end else begin
         // Tracks in every state so a bgn held high never retriggers.
         bgn_d <= bus.ctrl_bgn;
         case (state)
            IDLE: begin
               if (bus.ctrl_load) begin
                  sr  <= resp;
                  cnt <= CNT_LOAD;
               end
            end
            SHIFT: begin
               if (bus.ctrl_load) begin
                  // Restart: frame keeps its old value until a full frame lands.
                  sr  <= resp;
                  cnt <= CNT_LOAD;
               end else if (cnt != 8'd0) begin
                  sr  <= sr_shift;
                  cnt <= cnt - 8'd1;
                  if (cnt == 8'd1) begin
                     frame <= sr_shift;
                  end
               end
            end
            WRITE: begin
               resp <= frame;
            end
            RWAIT: begin
               // SRAM read data is valid the cycle after the READ access.
               resp <= {frame[REG_BITS_WIDTH-1:MEMORY_DATA_WIDTH], bus.sram_rdata};
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.ctrl_so    = sr[0];
   assign bus.ctrl_rdy   = (state == IDLE);
   assign bus.sram_cs    = (state == WRITE) || (state == READ);
   assign bus.sram_we    = (state == WRITE);
   assign bus.sram_addr  = frame[REG_BITS_WIDTH-1:MEMORY_DATA_WIDTH];
   assign bus.sram_wdata = frame[MEMORY_DATA_WIDTH-1:0];

endmodule
